// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART widths, receiver state encoding and divider helper
package uart_pkg;

  localparam int DIV_W  = 16;
  localparam int DATA_W = 8;

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_PARITY    = 3'd3;
  localparam logic [2:0] ST_STOP1     = 3'd4;
  localparam logic [2:0] ST_STOP2     = 3'd5;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd6;

  // A divider of zero behaves as one clock per bit.
  function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] div);
    return (div == '0) ? DIV_ONE : div;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period down-counter shared by UART receiver and transmitter
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clock_i,
  input  logic             reset_ni,
  input  logic             load,
  input  logic [DIV_W-1:0] value,
  output logic             expire
);

  logic [DIV_W-1:0] count_q;

  // Parks at zero when not reloaded, so an idle timer never wraps.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - DIV_ONE;
    end
  end

  assign expire = (count_q == DIV_ONE);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver: synchronizer, frame FSM, shift register and parity check
module uart_rx
  import uart_pkg::*;
(
  input  logic              clock_i,
  input  logic              reset_ni,
  input  logic              serial_i,
  input  logic              two_stop_bits_i,
  input  logic              parity_bit_i,
  input  logic              parity_even_i,
  input  logic [DIV_W-1:0]  clock_divider_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o,
  output logic              parity_error_o,
  output logic              framing_error_o,
  output logic              busy_o
);

  logic              sync1_q, sync2_q, prev_q;
  logic [2:0]        state_q;
  logic [DIV_W-1:0]  n_q;
  logic              two_stop_q, par_en_q, par_even_q;
  logic [DATA_W-1:0] shift_q;
  logic [2:0]        bit_cnt_q;
  logic              par_acc_q, par_err_q, frame_err_q;

  logic [DIV_W-1:0]  n_now, half_now;
  logic              fall, timer_load, timer_expire;
  logic [DIV_W-1:0]  timer_value;

  assign n_now    = eff_div(clock_divider_i);
  assign half_now = n_now >> 1;
  assign fall     = prev_q & ~sync2_q;

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      {sync1_q, sync2_q, prev_q} <= 3'b111;
    end else begin
      {sync1_q, sync2_q, prev_q} <= {serial_i, sync1_q, sync2_q};
    end
  end

  // With N=1 the detecting sample already sits mid start bit, so the
  // timer is armed straight for the first data bit.
  always_comb begin
    timer_load  = 1'b0;
    timer_value = n_q;
    if (state_q == ST_IDLE) begin
      if (fall) begin
        timer_load  = 1'b1;
        timer_value = (half_now == '0) ? n_now : half_now;
      end
    end else if (state_q != ST_WAIT_IDLE) begin
      timer_load = timer_expire;
    end
  end

  uart_bit_timer u_timer (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .load     (timer_load),
    .value    (timer_value),
    .expire   (timer_expire)
  );

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q         <= ST_IDLE;
      n_q             <= '0;
      two_stop_q      <= 1'b0;
      par_en_q        <= 1'b0;
      par_even_q      <= 1'b0;
      shift_q         <= '0;
      bit_cnt_q       <= '0;
      par_acc_q       <= 1'b0;
      par_err_q       <= 1'b0;
      frame_err_q     <= 1'b0;
      data_o          <= '0;
      valid_o         <= 1'b0;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      valid_o         <= 1'b0;
      parity_error_o  <= 1'b0;
      framing_error_o <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (fall) begin
            busy_o      <= 1'b1;
            n_q         <= n_now;
            two_stop_q  <= two_stop_bits_i;
            par_en_q    <= parity_bit_i;
            par_even_q  <= parity_even_i;
            bit_cnt_q   <= '0;
            par_acc_q   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
            state_q     <= (half_now == '0) ? ST_DATA : ST_START;
          end
        end
        ST_START: begin
          if (timer_expire) begin
            if (sync2_q) begin
              busy_o  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_DATA;
            end
          end
        end
        ST_DATA: begin
          if (timer_expire) begin
            shift_q   <= {sync2_q, shift_q[DATA_W-1:1]};
            par_acc_q <= par_acc_q ^ sync2_q;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= par_en_q ? ST_PARITY : ST_STOP1;
            end
          end
        end
        ST_PARITY: begin
          if (timer_expire) begin
            par_err_q <= sync2_q ^ par_acc_q ^ ~par_even_q;
            state_q   <= ST_STOP1;
          end
        end
        ST_STOP1, ST_STOP2: begin
          if (timer_expire) begin
            if (state_q == ST_STOP1 && two_stop_q) begin
              frame_err_q <= ~sync2_q;
              state_q     <= ST_STOP2;
            end else begin
              data_o          <= shift_q;
              valid_o         <= 1'b1;
              parity_error_o  <= par_err_q;
              framing_error_o <= frame_err_q | ~sync2_q;
              busy_o          <= 1'b0;
              state_q         <= sync2_q ? ST_IDLE : ST_WAIT_IDLE;
            end
          end
        end
        ST_WAIT_IDLE: begin
          if (sync2_q) begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized and directed bench for uart_rx against a frame-level model
module tb_uart_rx;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        serial = 1'b1;
  logic        two_stop = 1'b0;
  logic        par_en = 1'b0;
  logic        par_even = 1'b0;
  logic [15:0] div = 16'd4;
  logic [7:0]  data;
  logic        valid, perr, ferr, busy;

  always #5 clock = ~clock;

  uart_rx dut (
    .clock_i         (clock),
    .reset_ni        (reset_n),
    .serial_i        (serial),
    .two_stop_bits_i (two_stop),
    .parity_bit_i    (par_en),
    .parity_even_i   (par_even),
    .clock_divider_i (div),
    .data_o          (data),
    .valid_o         (valid),
    .parity_error_o  (perr),
    .framing_error_o (ferr),
    .busy_o          (busy)
  );

  typedef struct {
    logic [7:0] data;
    bit         perr;
    bit         ferr;
    longint     cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e_cur;
  longint     win_lo[$];
  longint     win_hi[$];
  logic [9:0] rx_hist[$];
  longint     cyc = 0;
  logic [7:0] last_data = 8'h00;
  int         total = 0;
  int         bad = 0;
  int         n_valid = 0;
  bit         exp_busy;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Scoreboard: every cycle the outputs are either a predicted frame or quiet.
  always @(negedge clock) begin
    if (valid) begin
      n_valid++;
      rx_hist.push_back({perr, ferr, data});
      check("spurious_valid", exp_q.size() == 0, 0);
      if (exp_q.size() > 0) begin
        e_cur = exp_q.pop_front();
        check("rx_data", data, e_cur.data);
        check("rx_parity_err", perr, e_cur.perr);
        check("rx_framing_err", ferr, e_cur.ferr);
        check("rx_valid_cycle", cyc, e_cur.cyc);
        last_data = e_cur.data;
      end
    end else begin
      check("quiet_flags", {perr, ferr}, 0);
      check("data_hold", data, last_data);
    end
    while (win_hi.size() > 0 && win_hi[0] <= cyc) begin
      void'(win_lo.pop_front());
      void'(win_hi.pop_front());
    end
    exp_busy = (win_lo.size() > 0) && (cyc >= win_lo[0]);
    check("busy", busy, exp_busy);
  end

  // Drives one frame from a negedge; bit k is sampled by the receiver at
  // detection + floor(N/2) + k*N, detection being two clocks after the line falls.
  task automatic send_frame(input logic [7:0] b, input int n_div, input bit pe, input bit pev,
                            input bit ts, input bit flip = 1'b0, input bit s1 = 1'b1,
                            input bit s2 = 1'b1, input int cut = 0);
    bit     bits[$];
    int     n, h, f;
    longint a;
    n = (n_div == 0) ? 1 : n_div;
    h = n / 2;
    div = 16'(n_div);
    par_en = pe;
    par_even = pev;
    two_stop = ts;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (pe) bits.push_back((pev ? ^b : ~^b) ^ flip);
    bits.push_back(s1);
    if (ts) bits.push_back(s2);
    f = bits.size() - 1;
    a = cyc + 1;
    win_lo.push_back(a + 2);
    win_hi.push_back(a + 2 + h + longint'(f) * n);
    if (cut == 0) exp_q.push_back('{b, flip & pe, !s1 | (ts & !s2), a + 2 + h + longint'(f) * n});
    for (int k = 0; k < bits.size(); k++) begin
      if (k == 4) begin
        div = 16'($urandom);
        par_en = 1'($urandom);
        par_even = 1'($urandom);
        two_stop = 1'($urandom);
      end
      serial = bits[k];
      for (int c = 0; c < n; c++) begin
        if (cut != 0 && k * n + c == cut) return;
        @(negedge clock);
      end
    end
  endtask

  task automatic idle(input int c);
    serial = 1'b1;
    repeat (c) @(negedge clock);
  endtask

  task automatic check_last(input string name, input logic [9:0] want);
    check(name, (rx_hist.size() > 0) ? rx_hist[rx_hist.size() - 1] : 10'h3ff, want);
  endtask

  initial begin
    int nv0;
    repeat (3) @(negedge clock);
    check("reset_data", data, 8'h00);
    check("reset_valid", valid, 0);
    check("reset_busy", busy, 0);
    check("reset_flags", {perr, ferr}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);

    // 8N1 back-to-back at N=4
    send_frame(8'h55, 4, 0, 0, 0);
    send_frame(8'hAA, 4, 0, 0, 0);
    idle(20);
    check("b2b_count", rx_hist.size(), 2);
    check("b2b_first", (rx_hist.size() > 1) ? rx_hist[rx_hist.size() - 2] : 10'h3ff, 10'h055);
    check_last("b2b_second", 10'h0AA);

    // even parity, 8'hA5: correct parity bit is 0
    send_frame(8'hA5, 16, 1, 1, 0, 1'b1);
    idle(5);
    check_last("parity_bad", 10'h2A5);
    send_frame(8'hA5, 16, 1, 1, 0, 1'b0);
    idle(5);
    check_last("parity_good", 10'h0A5);

    // second stop bit low, line then held low
    send_frame(8'h3C, 8, 0, 0, 1, 1'b0, 1'b1, 1'b0);
    serial = 1'b0;
    repeat (30) @(negedge clock);
    check_last("framing_err", 10'h13C);
    check("wait_idle_busy", busy, 0);
    nv0 = n_valid;
    idle(10);
    check("wait_idle_nvalid", n_valid, nv0);
    send_frame(8'h81, 8, 0, 0, 1);
    idle(10);
    check_last("rearm_frame", 10'h081);

    // false start: 4 low clocks at N=16
    nv0 = n_valid;
    div = 16'd16;
    win_lo.push_back(cyc + 3);
    win_hi.push_back(cyc + 11);
    serial = 1'b0;
    repeat (4) @(negedge clock);
    idle(40);
    check("false_start_nvalid", n_valid, nv0);
    check("false_start_busy", busy, 0);
    check("false_start_data", data, 8'h81);

    // reset in the middle of data bit 3 at N=8
    send_frame(8'h77, 8, 0, 0, 0, 1'b0, 1'b1, 1'b1, 36);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    serial = 1'b1;
    last_data = 8'h00;
    win_lo.delete();
    win_hi.delete();
    #1;
    check("midreset_outputs", {data, valid, busy, perr, ferr}, 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (3) @(negedge clock);
    send_frame(8'hF0, 8, 0, 0, 0);
    idle(10);
    check_last("after_reset_frame", 10'h0F0);

    // loopback sweep: N=1 in all six modes, N=5 rotating modes
    for (int m = 0; m < 6; m++) begin
      for (int b = 0; b < 256; b++) send_frame(8'(b), 1, (m % 3) != 0, (m % 3) == 1, m >= 3);
      idle(6);
    end
    for (int b = 0; b < 256; b++) send_frame(8'(b), 5, (b % 3) != 0, (b % 3) == 1, (b % 6) >= 3);
    idle(10);

    // random frames with random corruption and gaps
    for (int i = 0; i < 60; i++) begin
      int d;
      bit pe, pv, ts, fl, s1, s2;
      d  = $urandom_range(0, 12);
      pe = 1'($urandom);
      pv = 1'($urandom);
      ts = 1'($urandom);
      fl = ($urandom_range(0, 3) == 0);
      s1 = ($urandom_range(0, 3) != 0);
      s2 = ($urandom_range(0, 3) != 0);
      send_frame(8'($urandom), d, pe, pv, ts, fl, s1, s2);
      if (!(ts ? s2 : s1)) idle(((d == 0) ? 1 : d) + 3);
      else idle($urandom_range(0, 3));
    end
    idle(50);
    check("missing_valid", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
